// File: rtl/exe_muldiv_pkg.sv
// Shared encodings and constants for the EXE-stage multiply/divide unit.
package muldiv_pkg;
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;
endpackage

// File: rtl/exe_muldiv_if.sv
// EXE-side request/response bundle of the multiply/divide unit.
interface exe_muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        kill;
    logic        hilo_rd;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic        done;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, kill, hilo_rd, hi_we, lo_we,
        input  busy, done, stall_req, hi, lo
    );
    modport slave (
        input  start, op, src_a, src_b, kill, hilo_rd, hi_we, lo_we,
        output busy, done, stall_req, hi, lo
    );
endinterface

// File: rtl/exe_muldiv_step.sv
// One radix-2 step: shift-add multiply or restoring shift-subtract divide
// on a {upper, lower} 64-bit accumulator.
module exe_muldiv_step (
    input  logic        is_div_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] opnd_i,
    output logic [63:0] acc_o
);
    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic [32:0] diff;

    always_comb begin
        sum    = {1'b0, acc_i[63:32]} + {1'b0, opnd_i};
        rem_sh = acc_i[63:31];
        diff   = rem_sh - {1'b0, opnd_i};
        if (is_div_i) begin
            // A borrow out of bit 32 means the trial subtraction went negative.
            acc_o = diff[32] ? {rem_sh[31:0], acc_i[30:0], 1'b0}
                             : {diff[31:0],   acc_i[30:0], 1'b1};
        end else begin
            acc_o = acc_i[0] ? {sum, acc_i[31:1]} : {1'b0, acc_i[63:1]};
        end
    end
endmodule

// File: rtl/exe_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// EXE_MULDIV_FAST_MULT_EN: multiplies resolve in one cycle (IDLE -> FIX).
module exe_muldiv
    import muldiv_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    exe_muldiv_if.slave bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      acc_q, acc_d, step_acc;
    logic [31:0]      opnd_q, opnd_d, a_q, a_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d, neg_q, neg_d, negr_q, negr_d;
    logic             dz_q, dz_d, done_q, done_d;
    op_e              op;
    logic             sgn, div_op, busy;
    logic [31:0]      mag_a, mag_b;

    assign op     = op_e'(bus.op);
    assign sgn    = (op == OP_MULT) || (op == OP_DIV);
    assign div_op = (op == OP_DIV) || (op == OP_DIVU);
    assign mag_a  = (sgn && bus.src_a[31]) ? -bus.src_a : bus.src_a;
    assign mag_b  = (sgn && bus.src_b[31]) ? -bus.src_b : bus.src_b;

    assign busy          = (state_q != S_IDLE);
    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.stall_req = busy && (bus.start || bus.hilo_rd || bus.hi_we || bus.lo_we);

    exe_muldiv_step u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_d      = a_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else if (bus.start) begin
                    // Iterate on magnitudes; signs are reapplied in FIX.
                    is_div_d = div_op;
                    neg_d    = sgn && (bus.src_a[31] ^ bus.src_b[31]);
                    negr_d   = sgn && bus.src_a[31];
                    dz_d     = div_op && (bus.src_b == 32'd0);
                    a_d      = bus.src_a;
                    acc_d    = {32'd0, div_op ? mag_a : mag_b};
                    opnd_d   = div_op ? mag_b : mag_a;
                    cnt_d    = '0;
                    state_d  = S_CALC;
`ifdef EXE_MULDIV_FAST_MULT_EN
                    if (!div_op) begin
                        acc_d   = 64'(mag_a) * 64'(mag_b);
                        state_d = S_FIX;
                    end
`endif
                end else begin
                    if (bus.hi_we) hi_d = bus.src_a;
                    if (bus.lo_we) lo_d = bus.src_a;
                end
            end
            S_CALC: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.kill) begin
                    done_d = 1'b1;
                    if (is_div_q && dz_q) begin
                        lo_d = DIV0_QUO;
                        hi_d = a_q;
                    end else if (is_div_q) begin
                        lo_d = neg_q  ? -acc_q[31:0]  : acc_q[31:0];
                        hi_d = negr_q ? -acc_q[63:32] : acc_q[63:32];
                    end else begin
                        {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_q      <= a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Iterative multiply/divide unit with architectural HI/LO registers, sitting in the EXE stage directly downstream of the ID/EXE pipeline register. It consumes the decoded mult/div opcode and the forwarded ALU operands, runs a 32-step shift-add or shift-subtract sequence, and holds the pipeline via a stall request while busy. It also serves mfhi/mflo reads and mthi/mtlo writes.

## Interface
- ITER, 32, iteration count per multiply/divide (operand width).
- Clk  in  1  pipeline clock; all state updates on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- start  in  1  valid mult/div op presented in EXE this cycle.
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- src_a  in  32  forwarded Rs operand (multiplicand / dividend).
- src_b  in  32  forwarded Rt operand (multiplier / divisor).
- kill  in  1  flush of the EXE instruction (taken branch/jump).
- hilo_rd  in  1  mfhi or mflo in EXE.
- hi_we, lo_we  in  1 each  mthi / mtlo in EXE; data on src_a.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO updated this edge.
- stall_req  out  1  hold PC, IF/ID and ID/EXE.
- hi, lo  out  32 each  architectural HI/LO.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: start && !busy → capture operands; signed ops convert to magnitudes and record result signs; step counter = 0; → CALC.
- CALC: one radix-2 step per cycle (multiply: conditional add + shift right of 64-bit accumulator; divide: restoring shift-subtract, quotient bit in). After step ITER-1 → FIX.
- FIX: apply signs, write HI/LO, pulse done, → IDLE.
- Multiply: {HI,LO} = 64-bit product. Divide: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
- Divide by zero: LO = 32'hFFFF_FFFF, HI = src_a; full latency still taken.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0.
- stall_req = busy && (start || hilo_rd || hi_we || lo_we); combinational.
- hi_we/lo_we in IDLE: write src_a to HI/LO at the edge; same-cycle start with hi_we/lo_we: start wins, write dropped.
- kill in any state: abort, → IDLE next edge, HI/LO unchanged, no done. kill with start in IDLE: start ignored.
- start while busy: not accepted (stall_req holds it until IDLE).

## Timing
- Reset: state IDLE, busy 0, done 0, stall_req 0, hi 0, lo 0, counter 0.
- start sampled at edge k; busy high from k; CALC edges k+1..k+32; FIX edge k+33 writes HI/LO, done high for cycle after k+33, busy low from k+33.
- Back-to-back: new start accepted at edge k+33's following cycle (IDLE).
- Reset mid-operation: immediate return to reset values.

## Configuration
- EXE_MULDIV_FAST_MULT_EN defined: MULT/MULTU computed by a single-cycle 64-bit multiplier; state goes IDLE → FIX directly; done one cycle after start edge. DIV unchanged.
- Undefined: all ops use the 32-step iterative path.

## Structure
- Package muldiv_pkg: op encodings, state encoding, ITER, divide-by-zero quotient constant.
- One sub-module: exe_muldiv_step (combinational one-step shift-add / shift-subtract datapath); FSM, counter, sign fix and HI/LO in the top.

## Test plan
- MULT src_a=-3 (32'hFFFF_FFFD), src_b=7 → after 34 cycles HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB, done one cycle, stall_req with concurrent hilo_rd throughout busy.
- MULTU 32'hFFFF_FFFF × 32'hFFFF_FFFF → HI=32'hFFFF_FFFE, LO=32'h0000_0001.
- DIV -7 / 2 → LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; DIVU 100/0 → LO=32'hFFFF_FFFF, HI=100.
- Start DIV, assert kill at CALC step 10 → IDLE next edge, no done, HI/LO keep prior values; mthi 32'h1234 then hi=32'h1234.
- Assert Rst_n low at CALC step 5 → all outputs zero immediately; start after release completes normally.
- With EXE_MULDIV_FAST_MULT_EN: MULT 6×7 → LO=42, done one cycle after start edge.
